// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the digital-clock time registers: mode enum,
// field limits and the common time-field width.
`timescale 1ns/1ps
package clock_pkg;

  localparam int TIME_W = 6;

  localparam logic [TIME_W-1:0] HOUR_MAX   = 6'd23;
  localparam logic [TIME_W-1:0] MINSEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  // Mode button walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  function automatic state_t next_mode(input state_t s);
    case (s)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button/tick inputs and time/blank outputs of the time-set controller.
// master: the side driving ticks and buttons; slave: the controller.
`timescale 1ns/1ps
interface time_set_controller_if;
  import clock_pkg::*;

  logic              tick_1hz;
  logic              mode_btn;
  logic              inc_btn;
  logic [TIME_W-1:0] hour_out;
  logic [TIME_W-1:0] min_out;
  logic [TIME_W-1:0] sec_out;
  logic              setting;
  logic [2:0]        field_blank;

  modport master (
    output tick_1hz, mode_btn, inc_btn,
    input  hour_out, min_out, sec_out, setting, field_blank
  );

  modport slave (
    input  tick_1hz, mode_btn, inc_btn,
    output hour_out, min_out, sec_out, setting, field_blank
  );

endinterface

// File: rtl/time_set_controller_wrap_counter.sv
// Time-field counter counting 0..MAX and wrapping to 0. carry flags an
// increment that wraps, so the next field can chain on it. A value forced
// above MAX also wraps to 0 on its next increment.
`timescale 1ns/1ps
module wrap_counter
  import clock_pkg::*;
#(
  parameter logic [TIME_W-1:0] MAX = MINSEC_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [TIME_W-1:0] value,
  output logic              carry
);

  assign carry = inc & (value >= MAX);

  // Field register: clear on reset, step or wrap on inc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc) begin
      value <= (value >= MAX) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Wall-clock time sequencer: advances hh:mm:ss on tick_1hz in RUN and lets
// the user step through SET_HOUR/SET_MIN/SET_SEC with mode_btn, bumping the
// selected field with inc_btn. Optional blink strobes are built when
// TIME_SET_BLINK_EN is defined; otherwise field_blank is tied to zero.
`timescale 1ns/1ps
module time_set_controller
  import clock_pkg::*;
#(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  time_set_controller_if.slave bus
);

  if (BLINK_CYCLES < 2) begin : g_bad_blink_cycles
    $error("BLINK_CYCLES must be at least 2");
  end

  state_t            state_q, state_d;
  logic              in_run, inc_ok;
  logic              sec_inc, min_inc, hour_inc;
  logic              sec_carry, min_carry, hour_carry_unused;
  logic [TIME_W-1:0] sec_val, min_val, hour_val;

  assign in_run = (state_q == RUN);
  // A mode press in the same cycle swallows the increment.
  assign inc_ok = bus.inc_btn & ~bus.mode_btn;

  // In RUN the tick ripples through the carry chain; in set modes only the
  // selected field sees inc and carries are not forwarded.
  assign sec_inc  = in_run ? bus.tick_1hz : ((state_q == SET_SEC)  & inc_ok);
  assign min_inc  = in_run ? sec_carry    : ((state_q == SET_MIN)  & inc_ok);
  assign hour_inc = in_run ? min_carry    : ((state_q == SET_HOUR) & inc_ok);

  wrap_counter #(.MAX(MINSEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(sec_inc), .value(sec_val), .carry(sec_carry)
  );

  wrap_counter #(.MAX(MINSEC_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(min_inc), .value(min_val), .carry(min_carry)
  );

  wrap_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst_n(rst_n), .inc(hour_inc), .value(hour_val),
    .carry(hour_carry_unused)
  );

  // Mode state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next mode: only mode_btn moves the state.
  always_comb begin
    state_d = state_q;
    if (bus.mode_btn) state_d = next_mode(state_q);
  end

  assign bus.hour_out = hour_val;
  assign bus.min_out  = min_val;
  assign bus.sec_out  = sec_val;
  assign bus.setting  = ~in_run;

`ifdef TIME_SET_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_CYCLES);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;  // 1 = blank half-period

  // Blink timer: idle in RUN, restarted visible by any mode or valid inc.
  always_ff @(posedge clk) begin
    if (!rst_n || in_run || bus.mode_btn || inc_ok) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Blank strobe for the field being edited during the blank half-period.
  always_comb begin
    bus.field_blank = 3'b000;
    if (blink_phase) begin
      case (state_q)
        SET_HOUR: bus.field_blank = 3'b100;
        SET_MIN:  bus.field_blank = 3'b010;
        SET_SEC:  bus.field_blank = 3'b001;
        default:  bus.field_blank = 3'b000;
      endcase
    end
  end
`else
  assign bus.field_blank = 3'b000;
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// Testbench for time_set_controller: table-driven vectors plus hand-written
// sequences, all checked through an expected-value queue.
`timescale 1ns/1ps
module tb_time_set_controller;

`ifdef TIME_SET_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  time_set_controller_if tsc_if ();

  time_set_controller #(.BLINK_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tsc_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         h;
    int         mi;
    int         s;
    bit         st;
    bit         chk_blank;
    logic [2:0] blank;
    string      name;
  } exp_t;

  typedef struct {
    bit t;
    bit m;
    bit i;
    int h;
    int mi;
    int s;
    bit st;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model of the time registers and mode.
  int mst = 0;
  int mh = 0, mm = 0, ms = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".hour"},    32'(tsc_if.hour_out), e.h);
    cmp({e.name, ".min"},     32'(tsc_if.min_out),  e.mi);
    cmp({e.name, ".sec"},     32'(tsc_if.sec_out),  e.s);
    cmp({e.name, ".setting"}, 32'(tsc_if.setting),  32'(e.st));
    if (e.chk_blank) cmp({e.name, ".blank"}, 32'(tsc_if.field_blank), 32'(e.blank));
  endtask

  task automatic model_adv();
    if (ms == 59) begin
      ms = 0;
      if (mm == 59) begin
        mm = 0;
        mh = (mh == 23) ? 0 : mh + 1;
      end else mm++;
    end else ms++;
  endtask

  task automatic model_step(input bit t, input bit m, input bit i);
    if (m) begin
      if (mst == 0 && t) model_adv();
      mst = (mst + 1) % 4;
    end else if (mst == 0) begin
      if (t) model_adv();
    end else if (i) begin
      case (mst)
        1: mh = (mh >= 23) ? 0 : mh + 1;
        2: mm = (mm >= 59) ? 0 : mm + 1;
        default: ms = (ms >= 59) ? 0 : ms + 1;
      endcase
    end
  endtask

  function automatic exp_t model_exp(input string nm);
    exp_t e;
    e.h = mh; e.mi = mm; e.s = ms;
    e.st = (mst != 0);
    e.chk_blank = (mst == 0);
    e.blank = 3'b000;
    e.name = nm;
    return e;
  endfunction

  function automatic exp_t const_exp(input int h, input int mi, input int s,
                                     input bit st, input string nm);
    exp_t e;
    e.h = h; e.mi = mi; e.s = s; e.st = st;
    e.chk_blank = !st;
    e.blank = 3'b000;
    e.name = nm;
    return e;
  endfunction

  task automatic apply(input bit t, input bit m, input bit i);
    tsc_if.tick_1hz = t;
    tsc_if.mode_btn = m;
    tsc_if.inc_btn  = i;
    @(posedge clk);
    #1;
    tsc_if.tick_1hz = 1'b0;
    tsc_if.mode_btn = 1'b0;
    tsc_if.inc_btn  = 1'b0;
    check_out();
  endtask

  // Model-checked cycle.
  task automatic step(input bit t, input bit m, input bit i, input string nm);
    model_step(t, m, i);
    sb.push_back(model_exp(nm));
    apply(t, m, i);
  endtask

  // Cycle checked against constants written in the bench.
  task automatic step_const(input bit t, input bit m, input bit i,
                            input int h, input int mi, input int s,
                            input bit st, input string nm);
    model_step(t, m, i);
    sb.push_back(const_exp(h, mi, s, st, nm));
    apply(t, m, i);
  endtask

  // Cycle with an explicit blank-strobe expectation.
  task automatic step_blink(input bit m, input bit i, input logic [2:0] bl,
                            input string nm);
    exp_t e;
    model_step(1'b0, m, i);
    e = model_exp(nm);
    e.chk_blank = 1'b1;
    e.blank = bl;
    sb.push_back(e);
    apply(1'b0, m, i);
  endtask

  task automatic do_reset(input bit t, input string nm);
    mst = 0; mh = 0; mm = 0; ms = 0;
    sb.push_back(const_exp(0, 0, 0, 1'b0, nm));
    rst_n = 1'b0;
    tsc_if.tick_1hz = t;
    tsc_if.mode_btn = t;
    tsc_if.inc_btn  = t;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tsc_if.tick_1hz = 1'b0;
    tsc_if.mode_btn = 1'b0;
    tsc_if.inc_btn  = 1'b0;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [17];
    logic [2:0] bl;

    tsc_if.tick_1hz = 1'b0;
    tsc_if.mode_btn = 1'b0;
    tsc_if.inc_btn  = 1'b0;

    tab[0]  = '{1, 0, 0, 0, 0, 1, 0};
    tab[1]  = '{0, 1, 0, 0, 0, 1, 1};
    tab[2]  = '{0, 0, 1, 1, 0, 1, 1};
    tab[3]  = '{1, 0, 0, 1, 0, 1, 1};
    tab[4]  = '{0, 1, 1, 1, 0, 1, 1};
    tab[5]  = '{0, 0, 1, 1, 1, 1, 1};
    tab[6]  = '{0, 1, 1, 1, 1, 1, 1};
    tab[7]  = '{0, 0, 1, 1, 1, 2, 1};
    tab[8]  = '{1, 0, 0, 1, 1, 2, 1};
    tab[9]  = '{1, 0, 1, 1, 1, 3, 1};
    tab[10] = '{0, 1, 0, 1, 1, 3, 0};
    tab[11] = '{0, 0, 1, 1, 1, 3, 0};
    tab[12] = '{1, 0, 1, 1, 1, 4, 0};
    tab[13] = '{1, 1, 0, 1, 1, 5, 1};
    tab[14] = '{0, 1, 0, 1, 1, 5, 1};
    tab[15] = '{0, 1, 0, 1, 1, 5, 1};
    tab[16] = '{0, 1, 0, 1, 1, 5, 0};

    repeat (2) @(posedge clk);
    #1;

    // Reset state, then the vector table.
    do_reset(1'b0, "reset0");
    for (int k = 0; k < 17; k++) begin
      step_const(tab[k].t, tab[k].m, tab[k].i, tab[k].h, tab[k].mi, tab[k].s,
                 tab[k].st, $sformatf("vec%0d", k));
    end

    // 61 ticks from reset, then reset mid-run with inputs active.
    do_reset(1'b0, "reset_run");
    for (int k = 0; k < 60; k++) step(1'b1, 1'b0, 1'b0, $sformatf("tick%0d", k));
    step_const(1'b1, 1'b0, 1'b0, 0, 1, 1, 1'b0, "tick61");
    repeat (3) step(1'b1, 1'b0, 1'b0, "tick_more");
    do_reset(1'b1, "reset_midrun");

    // 00:59:59 -> 01:00:00 carry chain.
    step(1'b0, 1'b1, 1'b0, "c1_mode_h");
    step(1'b0, 1'b1, 1'b0, "c1_mode_m");
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1, "c1_inc_m");
    step(1'b0, 1'b1, 1'b0, "c1_mode_s");
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1, "c1_inc_s");
    step_const(1'b0, 1'b1, 1'b0, 0, 59, 59, 1'b0, "c1_run");
    step_const(1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0, "c1_carry");

    // Full rollover 23:59:59 -> 00:00:00.
    do_reset(1'b0, "reset_roll");
    step(1'b0, 1'b1, 1'b0, "r_mode_h");
    for (int k = 0; k < 23; k++) step(1'b0, 1'b0, 1'b1, "r_inc_h");
    step(1'b0, 1'b1, 1'b0, "r_mode_m");
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1, "r_inc_m");
    step(1'b0, 1'b1, 1'b0, "r_mode_s");
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1, "r_inc_s");
    step_const(1'b0, 1'b1, 1'b0, 23, 59, 59, 1'b0, "r_run");
    step_const(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, "r_rollover");

    // Field setting with wrap and frozen time.
    do_reset(1'b0, "reset_set");
    step(1'b0, 1'b1, 1'b0, "f_mode_h");
    for (int k = 0; k < 24; k++) step(1'b0, 1'b0, 1'b1, "f_inc_h");
    step_const(1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b1, "f_hour_wrap");
    step_const(1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b1, "f_tick_hold_h");
    step(1'b0, 1'b1, 1'b0, "f_mode_m");
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b1, "f_inc_m");
    step_const(1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b1, "f_min_wrap");
    step_const(1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b1, "f_tick_hold_m");
    step_const(1'b0, 1'b1, 1'b1, 1, 0, 0, 1'b1, "f_mode_inc_min");

    // mode + tick in RUN at 00:00:59.
    do_reset(1'b0, "reset_coll");
    for (int k = 0; k < 59; k++) step(1'b1, 1'b0, 1'b0, "d_tick");
    step_const(1'b1, 1'b1, 1'b0, 0, 1, 0, 1'b1, "d_mode_tick");

    // Blink pattern in SET_MIN and restart on inc.
    do_reset(1'b0, "reset_blink");
    step(1'b0, 1'b1, 1'b0, "b_mode_h");
    step_blink(1'b1, 1'b0, 3'b000, "b_enter_min");
    for (int k = 1; k <= 12; k++) begin
      bl = (BLINK_ON && ((k / 4) % 2 == 1)) ? 3'b010 : 3'b000;
      step_blink(1'b0, 1'b0, bl, $sformatf("b_idle%0d", k));
    end
    step_blink(1'b0, 1'b1, 3'b000, "b_inc");
    for (int k = 1; k <= 4; k++) begin
      bl = (BLINK_ON && k == 4) ? 3'b010 : 3'b000;
      step_blink(1'b0, 1'b0, bl, $sformatf("b_after_inc%0d", k));
    end
    step_blink(1'b1, 1'b0, 3'b000, "b_enter_sec");
    step_blink(1'b1, 1'b0, 3'b000, "b_run");

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequencer owning the wall-clock time registers of the digital clock. Advances hour/minute/second on a 1 Hz tick in run mode, and lets the user set each field in turn with two debounced buttons. Its hour/min/sec outputs feed the 12/24-hour display-mode block. In set modes it also drives per-field blank strobes for blinking.

## Interface

Parameters:
- BLINK_CYCLES, default 25_000_000: clk cycles per blink half-period. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tick_1hz  input  1  one-cycle pulse, once per second.
- mode_btn  input  1  one-cycle pulse, already debounced; advances the mode.
- inc_btn  input  1  one-cycle pulse, already debounced; increments the selected field.
- hour_out  output  6  hours, 0..23.
- min_out  output  6  minutes, 0..59.
- sec_out  output  6  seconds, 0..59.
- setting  output  1  high in any set state.
- field_blank  output  3  one-hot blank strobe: bit2 = hour, bit1 = min, bit0 = sec.

## Operation

- States: RUN, SET_HOUR, SET_MIN, SET_SEC.
- mode_btn cycles RUN → SET_HOUR → SET_MIN → SET_SEC → RUN. Nothing else changes state.
- RUN, on tick_1hz:
  - sec increments. 59 → 0 carries into min.
  - min 59 → 0 carries into hour.
  - hour 23 → 0.
  - inc_btn is ignored.
- SET_x:
  - tick_1hz is dropped, not queued, so time is frozen.
  - inc_btn increments only the selected field, with wrap: hour 23 → 0, min/sec 59 → 0. No carry into other fields.
- Simultaneous mode_btn and inc_btn: mode_btn wins and inc_btn is discarded.
- Simultaneous mode_btn and tick_1hz in RUN:
  - the tick is applied, including carries;
  - the state moves to SET_HOUR in the same cycle.
- setting = (state != RUN).
- Field widths:
  - 6-bit unsigned.
  - Out-of-range values are unreachable. If one is forced, the next increment wraps it to 0.
- Reset (rst_n low at a clk edge), including mid-set:
  - state = RUN, hour/min/sec = 0;
  - setting = 0, field_blank = 0;
  - blink counter and phase = 0.

## Timing

- All outputs are registered. An event sampled at edge N is visible after edge N.
- Latency from tick, inc or mode to output is 1 cycle.
- Carry chain: 00:59:59 + tick gives 01:00:00 in one cycle. 23:59:59 + tick gives 00:00:00.
- Back-to-back pulses on consecutive cycles are each honoured, one increment or mode step per cycle.
- Blink counter:
  - runs only in set states;
  - toggles the blink phase every BLINK_CYCLES cycles;
  - every mode_btn clears the counter and sets phase = visible.
- field_blank: selected field's bit is high while phase = blank; otherwise 0. Always 0 in RUN.
- An inc_btn restarts the phase at visible, so the field shows immediately after a change.

## Configuration

- TIME_SET_BLINK_EN defined:
  - the blink counter and phase logic are present;
  - field_blank behaves as above.
- Undefined:
  - no blink counter is synthesised;
  - field_blank is constant 3'b000;
  - BLINK_CYCLES is unused;
  - all other behaviour is identical.

## Structure

- Shared package clock_pkg holds:
  - the state enum (RUN, SET_HOUR, SET_MIN, SET_SEC);
  - HOUR_MAX = 23 and MINSEC_MAX = 59;
  - the 6-bit time field width.
- Sub-module wrap_counter:
  - 6-bit mod-(MAX+1) counter with inc input and carry output;
  - MAX is a parameter;
  - instantiated three times (sec, min, hour);
  - the FSM gates each inc.

## Test plan

- Reset and run: release rst_n, apply 61 ticks → 00:01:01, setting = 0, field_blank = 0. Assert rst_n low mid-run → 00:00:00, RUN, on the next edge.
- Full rollover: set to 23:59:59 via the set modes, return to RUN, one tick → 00:00:00 one cycle later.
- Field setting: mode_btn once, inc_btn ×25 → hour = 1. mode_btn, inc_btn ×60 → min = 0. Sec unchanged with no carry. Ticks during the set states leave the time unchanged.
- Collisions:
  - mode_btn + inc_btn in SET_MIN → state SET_SEC, min unchanged.
  - mode_btn + tick in RUN at 00:00:59 → 00:01:00 and state SET_HOUR.
- Blink (BLINK_CYCLES = 4, TIME_SET_BLINK_EN defined):
  - in SET_MIN, field_blank = 000 for 4 cycles, then 010 for 4, repeating;
  - inc_btn forces 000 for the next 4 cycles.
  - Rebuilt without the macro: field_blank stays 000 throughout.
